// File: rtl/noc_injector.sv
// noc_injector -- local injection stage between a tile's core-side message
// interface and the local input port of a router node.
//
// A message (descriptor + payload words) is first collected into an internal
// buffer, then serialised as HEADER, DATA*, TAIL on the down port. Because
// the whole packet is buffered before sending, enable stays high from HEADER
// to TAIL without gaps once the router has taken the header.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   msg_valid/msg_ready      descriptor handshake (msg_dst, msg_len)
//   data_valid/data_ready    payload word handshake (data)
//   flit/enable/ack          down-port flit handshake
//   busy                     high whenever not IDLE

package noc_pkg;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } addr_t;

  typedef enum logic [1:0] {
    FT_NONE   = 2'b00,
    FT_HEADER = 2'b01,
    FT_DATA   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_t;

  typedef struct packed {
    addr_t                                dst_addr;
    addr_t                                src_addr;
    logic [PAYLOAD_W-2*$bits(addr_t)-1:0] rsvd;
  } flit_hdr_t;

  typedef struct packed {
    flit_type_t           ftype;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
endpackage

module noc_injector
  import noc_pkg::*;
#(
  parameter int X       = 0,
  parameter int Y       = 0,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [$bits(addr_t)-1:0]   msg_dst,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic [PAYLOAD_W-1:0]       data,
  output logic [$bits(flit_t)-1:0]   flit,
  output logic                       enable,
  input  logic                       ack,
  output logic                       busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND_HDR, SEND_BODY} state_t;

  state_t               state, state_nxt;
  addr_t                dst_q;
  logic [LEN_W-1:0]     len_q, wr_cnt, rd_cnt, len_sat;
  logic [PAYLOAD_W-1:0] pbuf [MAX_LEN];
  logic                 last_wr, last_rd;
  flit_hdr_t            hdr;
  flit_t                flit_c;

  // Overlength requests are clamped; the core is expected to supply only
  // MAX_LEN words in that case.
  assign len_sat = (msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : msg_len;
  assign last_wr = (wr_cnt == len_q - LEN_W'(1));
  // An empty message still needs a TAIL, so the first body flit is last.
  assign last_rd = (len_q == '0) || (rd_cnt == len_q - LEN_W'(1));

  always_comb begin
    hdr          = '0;
    hdr.dst_addr = dst_q;
    hdr.src_addr.x = COORD_W'(X);
    hdr.src_addr.y = COORD_W'(Y);
  end

  always_comb begin
    state_nxt  = state;
    msg_ready  = 1'b0;
    data_ready = 1'b0;
    enable     = 1'b0;
    flit_c     = '0;
    case (state)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        msg_ready = !rst;
        if (msg_valid) state_nxt = (len_sat == '0) ? SEND_HDR : LOAD;
      end
      LOAD: begin
        data_ready = (wr_cnt < len_q);
        if (data_valid && data_ready && last_wr) state_nxt = SEND_HDR;
      end
      SEND_HDR: begin
        enable         = 1'b1;
        flit_c.ftype   = FT_HEADER;
        flit_c.payload = hdr;
        if (ack) state_nxt = SEND_BODY;
      end
      SEND_BODY: begin
        enable         = 1'b1;
        flit_c.ftype   = last_rd ? FT_TAIL : FT_DATA;
        flit_c.payload = (len_q == '0) ? '0 : pbuf[rd_cnt[IDX_W-1:0]];
        if (ack && last_rd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign flit = flit_c;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dst_q  <= '0;
      len_q  <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (msg_valid) begin
          dst_q  <= msg_dst;
          len_q  <= len_sat;
          wr_cnt <= '0;
        end
        LOAD:      if (data_valid && data_ready) wr_cnt <= wr_cnt + LEN_W'(1);
        SEND_HDR:  if (ack) rd_cnt <= '0;
        SEND_BODY: if (ack) rd_cnt <= rd_cnt + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; contents are don't-care after abort.
  always_ff @(posedge clk) begin
    if (state == LOAD && data_valid && data_ready)
      pbuf[wr_cnt[IDX_W-1:0]] <= data;
  end

  // Down-port protocol checks.
  ap_stable: assert property (@(posedge clk) disable iff (rst)
    (enable && !ack) |=> (enable && $stable(flit)));
  ap_no_gap: assert property (@(posedge clk) disable iff (rst)
    (enable && ack && flit_c.ftype != FT_TAIL) |=> enable);
  ap_hdr_first: assert property (@(posedge clk) disable iff (rst)
    $rose(enable) |-> (flit_c.ftype == FT_HEADER));
  ap_body_after_hdr: assert property (@(posedge clk) disable iff (rst)
    (enable && ack && flit_c.ftype == FT_HEADER) |=>
      (flit_c.ftype == FT_DATA || flit_c.ftype == FT_TAIL));

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector (X=1, Y=1, MAX_LEN=8).
module tb_noc_injector;
  import noc_pkg::*;

  localparam int FW = $bits(flit_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_valid, msg_ready;
  logic [7:0]    msg_dst;
  logic [3:0]    msg_len;
  logic          data_valid, data_ready;
  logic [31:0]   data;
  logic [FW-1:0] flit;
  logic          enable, ack, busy;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  noc_injector #(.X(1), .Y(1), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_dst(msg_dst), .msg_len(msg_len),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .flit(flit), .enable(enable), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Enable-cycle counter sampled mid-cycle.
  always @(negedge clk) if (enable === 1'b1) en_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkf(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  // Header payload: {dst, src=(1,1), 16'h0}.
  function automatic logic [FW-1:0] mkh(input logic [7:0] dst);
    return {FT_HEADER, dst, 8'h11, 16'h0000};
  endfunction

  initial begin
    int base;
    int acc;
    rst = 1'b1; msg_valid = 0; msg_dst = 0; msg_len = 0;
    data_valid = 0; data = 0; ack = 0;

    // ---- reset state
    tick(); tick();
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_flit", flit, 0);
    rst = 1'b0; #1;
    chk("idle_msg_ready", msg_ready, 1);

    // ---- basic packet: dst=(2,3) len=3, ack held high
    ack = 1; msg_valid = 1; msg_dst = 8'h23; msg_len = 3;
    tick();
    msg_valid = 0; msg_dst = 8'hFF; msg_len = 7;   // ignored after handshake
    base = en_cnt;
    chk("b_load_busy", busy, 1);
    chk("b_load_msg_ready", msg_ready, 0);
    chk("b_load_data_ready", data_ready, 1);
    data_valid = 1;
    for (int i = 0; i < 3; i++) begin
      data = 32'hA000_0000 + i;
      chk("b_load_no_enable", enable, 0);
      tick();
    end
    data_valid = 0;
    chk("b_hdr", flit, mkh(8'h23));
    chk("b_hdr_en", enable, 1);
    tick(); chk("b_data0", flit, mkf(FT_DATA, 32'hA000_0000));
    tick(); chk("b_data1", flit, mkf(FT_DATA, 32'hA000_0001));
    tick(); chk("b_tail", flit, mkf(FT_TAIL, 32'hA000_0002));
    tick();
    chk("b_idle_en", enable, 0);
    chk("b_idle_msg_ready", msg_ready, 1);
    chk("b_en_cycles", en_cnt - base, 4);

    // ---- empty payload
    msg_valid = 1; msg_dst = 8'h34; msg_len = 0;
    tick();
    msg_valid = 0;
    base = en_cnt;
    chk("e_data_ready", data_ready, 0);
    chk("e_hdr", flit, mkh(8'h34));
    tick();
    chk("e_data_ready2", data_ready, 0);
    chk("e_tail", flit, mkf(FT_TAIL, 32'h0));
    tick();
    chk("e_idle_en", enable, 0);
    tick();
    chk("e_en_cycles", en_cnt - base, 2);

    // ---- ack stalls: len=2, 3 stalled edges on header, 2 on first DATA
    ack = 0; msg_valid = 1; msg_dst = 8'h45; msg_len = 2;
    tick();
    msg_valid = 1;              // must not be accepted while busy
    msg_dst = 8'h99;
    data_valid = 1;
    data = 32'hD000_0000; tick();
    chk("s_msg_ready_busy", msg_ready, 0);
    data = 32'hD000_0001; tick();
    data_valid = 0; msg_valid = 0;
    base = en_cnt;
    chk("s_hdr", flit, mkh(8'h45));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_hdr_hold", flit, mkh(8'h45));
      chk("s_hdr_hold_en", enable, 1);
    end
    ack = 1; tick(); ack = 0;
    chk("s_data0", flit, mkf(FT_DATA, 32'hD000_0000));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s_data0_hold", flit, mkf(FT_DATA, 32'hD000_0000));
      chk("s_data0_hold_en", enable, 1);
    end
    ack = 1; tick();
    chk("s_tail", flit, mkf(FT_TAIL, 32'hD000_0001));
    tick();
    chk("s_idle_en", enable, 0);
    tick();
    // 3 flits + 3 header stall cycles + 2 data stall cycles
    chk("s_en_cycles", en_cnt - base, 8);

    // ---- slow producer: len=8, data_valid every other cycle
    msg_valid = 1; msg_dst = 8'h12; msg_len = 8;
    tick();
    msg_valid = 0;
    for (int i = 0; i < 8; i++) begin
      data_valid = 1; data = 32'hB000_0000 + i;
      tick();
      data_valid = 0;
      if (i < 7) begin
        chk("p_no_enable_a", enable, 0);
        tick();
        chk("p_no_enable_b", enable, 0);
      end
    end
    base = en_cnt;
    chk("p_hdr", flit, mkh(8'h12));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("p_body", flit, mkf((i == 7) ? FT_TAIL : FT_DATA, 32'hB000_0000 + i));
    end
    tick();
    chk("p_idle_en", enable, 0);
    tick();
    chk("p_en_cycles", en_cnt - base, 9);

    // ---- overlength: msg_len=12 clamps to 8
    ack = 0; msg_valid = 1; msg_dst = 8'h67; msg_len = 12;
    tick();
    msg_valid = 0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      data_valid = 1; data = 32'hC000_0000 + i;
      if (data_ready) acc++;
      tick();
    end
    data_valid = 0;
    chk("o_accepted", acc, 8);
    chk("o_hdr", flit, mkh(8'h67));
    ack = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("o_body", flit, mkf((i == 7) ? FT_TAIL : FT_DATA, 32'hC000_0000 + i));
    end
    tick();
    chk("o_idle_en", enable, 0);

    // ---- reset mid SEND_BODY
    msg_valid = 1; msg_dst = 8'h89; msg_len = 4;
    tick();
    msg_valid = 0; data_valid = 1;
    for (int i = 0; i < 4; i++) begin
      data = 32'hE000_0000 + i;
      tick();
    end
    data_valid = 0;
    chk("r_hdr", flit, mkh(8'h89));
    tick(); chk("r_data0", flit, mkf(FT_DATA, 32'hE000_0000));
    tick(); chk("r_data1", flit, mkf(FT_DATA, 32'hE000_0001));
    tick(); chk("r_data2", flit, mkf(FT_DATA, 32'hE000_0002));
    rst = 1; #1;
    chk("r_rst_en", enable, 0);
    chk("r_rst_busy", busy, 0);
    chk("r_rst_flit", flit, 0);
    tick();
    rst = 0; #1;
    chk("r_rel_msg_ready", msg_ready, 1);
    chk("r_rel_busy", busy, 0);
    msg_valid = 1; msg_dst = 8'hAB; msg_len = 1;
    tick();
    msg_valid = 0;
    chk("r_load_data_ready", data_ready, 1);
    data_valid = 1; data = 32'h5555_5555;
    tick();
    data_valid = 0;
    chk("r2_hdr", flit, mkh(8'hAB));
    tick(); chk("r2_tail", flit, mkf(FT_TAIL, 32'h5555_5555));
    tick();
    chk("r2_idle_en", enable, 0);
    chk("r2_msg_ready", msg_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
